// File: rtl/rom_oscillator_burst_ctrl.sv
// rom_oscillator_burst_ctrl: sequences a cosine ROM oscillator into phase-aligned tone bursts
// and gates its sample stream, compensating for the oscillator latency.
module rom_oscillator_burst_ctrl #(
  parameter int INT_DATA_WIDTH = 20,
  parameter int INT_SAMPLES_PER_PERIOD = 5,
  parameter int INT_CNT_WIDTH = 16,
  parameter int INT_OSC_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_start,
  input  logic                             i_abort,
  input  logic [INT_CNT_WIDTH-1:0]         i_periods,
  input  logic [INT_CNT_WIDTH-1:0]         i_gap_cycles,
  input  logic [INT_CNT_WIDTH-1:0]         i_bursts,
  output logic                             o_osc_phase_rst,
  output logic                             o_osc_valid,
  input  logic                             i_osc_valid,
  input  logic signed [INT_DATA_WIDTH-1:0] i_cos,
  output logic                             o_valid,
  output logic signed [INT_DATA_WIDTH-1:0] o_data,
  output logic                             o_busy,
  output logic                             o_done
);
  localparam int SW = $clog2(INT_SAMPLES_PER_PERIOD);
  localparam int L = INT_OSC_LATENCY;
  typedef enum logic [2:0] {IDLE, ALIGN, BURST, GAP, DONE} state_t;
  state_t state;
  logic [INT_CNT_WIDTH-1:0] n_q, g_q, b_q, period_cnt, gap_cnt, burst_cnt;
  logic [SW-1:0] sample_cnt;
  logic [L-1:0] gate_sr;
  logic gate_d, osc_fire, sample_last, period_last, burst_last, gap_last, abort_hit;
  assign gate_d = gate_sr[L-1];
  assign osc_fire = gate_d & i_osc_valid;
  assign sample_last = sample_cnt == SW'(INT_SAMPLES_PER_PERIOD - 1);
  assign period_last = sample_last && period_cnt == n_q - 1'b1;
  assign burst_last = burst_cnt == b_q - 1'b1;
  assign gap_last = gap_cnt == g_q - 1'b1;
  assign abort_hit = i_abort && state != IDLE && state != DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      n_q <= '0;
      g_q <= '0;
      b_q <= '0;
      period_cnt <= '0;
      gap_cnt <= '0;
      burst_cnt <= '0;
      sample_cnt <= '0;
      gate_sr <= '0;
      o_osc_phase_rst <= 1'b0;
      o_osc_valid <= 1'b0;
      o_valid <= 1'b0;
      o_data <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_osc_phase_rst <= 1'b0;
      o_done <= 1'b0;
      gate_sr <= (gate_sr << 1) | L'(state == BURST);
      o_valid <= osc_fire;
      o_data <= osc_fire ? i_cos : '0;
      if (abort_hit) begin
        // flush the delayed gate so nothing already in flight reaches the output
        state <= DONE;
        o_osc_valid <= 1'b0;
        o_done <= 1'b1;
        gate_sr <= '0;
        o_valid <= 1'b0;
        o_data <= '0;
      end else begin
        case (state)
          IDLE: if (i_start && !i_abort) begin
            n_q <= i_periods;
            g_q <= i_gap_cycles;
            b_q <= i_bursts;
            burst_cnt <= '0;
            o_busy <= 1'b1;
            if (i_periods == '0 || i_bursts == '0) begin
              state <= DONE;
              o_done <= 1'b1;
            end else begin
              state <= ALIGN;
              o_osc_phase_rst <= 1'b1;
            end
          end
          ALIGN: begin
            state <= BURST;
            o_osc_valid <= 1'b1;
            sample_cnt <= '0;
            period_cnt <= '0;
          end
          BURST: begin
            sample_cnt <= sample_last ? '0 : sample_cnt + 1'b1;
            if (sample_last) period_cnt <= period_cnt + 1'b1;
            if (period_last) begin
              o_osc_valid <= 1'b0;
              burst_cnt <= burst_cnt + 1'b1;
              gap_cnt <= '0;
              if (burst_last) begin
                state <= DONE;
                o_done <= 1'b1;
              end else if (g_q != '0) begin
                state <= GAP;
              end else begin
                state <= ALIGN;
                o_osc_phase_rst <= 1'b1;
              end
            end
          end
          GAP: begin
            gap_cnt <= gap_cnt + 1'b1;
            if (gap_last) begin
              state <= ALIGN;
              o_osc_phase_rst <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            o_busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rom_oscillator_burst_ctrl.sv
// tb_rom_oscillator_burst_ctrl: scenario tasks plus an oscillator model and output scoreboard.
module tb_rom_oscillator_burst_ctrl;
  localparam int W = 20;
  localparam int SPP = 5;
  localparam int CW = 16;
  logic clk = 0, rst_n = 0, i_start = 0, i_abort = 0;
  logic [CW-1:0] i_periods = '0, i_gap_cycles = '0, i_bursts = '0;
  logic o_osc_phase_rst, o_osc_valid, o_valid, o_busy, o_done;
  logic i_osc_valid;
  logic signed [W-1:0] i_cos, o_data;
  int cyc = 0, total = 0, bad = 0, nvalid = 0, first_valid = -1, ptr = 0;
  logic signed [W-1:0] tbl [SPP] = '{20'sd524287, 20'sd162014, -20'sd424157, -20'sd424157, 20'sd162014};
  logic signed [W-1:0] exp_q [$];

  rom_oscillator_burst_ctrl #(.INT_DATA_WIDTH(W), .INT_SAMPLES_PER_PERIOD(SPP),
    .INT_CNT_WIDTH(CW), .INT_OSC_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_periods(i_periods), .i_gap_cycles(i_gap_cycles), .i_bursts(i_bursts),
    .o_osc_phase_rst(o_osc_phase_rst), .o_osc_valid(o_osc_valid),
    .i_osc_valid(i_osc_valid), .i_cos(i_cos), .o_valid(o_valid), .o_data(o_data),
    .o_busy(o_busy), .o_done(o_done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // oscillator with one cycle of latency and a clearable ROM pointer
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 0;
      i_osc_valid <= 1'b0;
      i_cos <= '0;
    end else begin
      i_osc_valid <= o_osc_valid;
      if (o_osc_valid) i_cos <= tbl[ptr];
      if (o_osc_phase_rst) ptr <= 0;
      else if (o_osc_valid) ptr <= (ptr + 1) % SPP;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid) begin
        nvalid++;
        if (first_valid < 0) first_valid = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sample_unexpected got=%0d want=none cyc=%0d", o_data, cyc);
        end else begin
          logic signed [W-1:0] e;
          e = exp_q.pop_front();
          if (o_data !== e) begin
            bad++;
            $display("FAIL sample got=%0d want=%0d cyc=%0d", o_data, e, cyc);
          end
        end
      end else if (o_data !== '0) begin
        total++;
        bad++;
        $display("FAIL idle_data got=%0d want=0 cyc=%0d", o_data, cyc);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input int n, input int b);
    for (int k = 0; k < b; k++)
      for (int i = 0; i < n * SPP; i++) exp_q.push_back(tbl[i % SPP]);
  endtask

  // expected control per cycle: 0 idle, 1 align, 2 burst, 3 gap, 4 done
  task automatic run_seq(input int n, input int g, input int b, input int inj, output int t0);
    int sq [$];
    logic [3:0] got, want;
    if (n == 0 || b == 0) sq.push_back(4);
    else begin
      for (int k = 0; k < b; k++) begin
        sq.push_back(1);
        repeat (n * SPP) sq.push_back(2);
        if (k < b - 1) repeat (g) sq.push_back(3);
      end
      sq.push_back(4);
      push_exp(n, b);
    end
    sq.push_back(0);
    t0 = cyc;
    i_start = 1;
    i_periods = CW'(n);
    i_gap_cycles = CW'(g);
    i_bursts = CW'(b);
    step();
    for (int k = 0; k < sq.size(); k++) begin
      i_start = 0;
      i_periods = CW'($urandom);
      i_gap_cycles = CW'($urandom);
      i_bursts = CW'($urandom);
      got = {o_osc_phase_rst, o_osc_valid, o_done, o_busy};
      want = {sq[k] == 1, sq[k] == 2, sq[k] == 4, sq[k] != 0};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL ctl k=%0d got=%b want=%b", k, got, want);
      end
      if (k == inj) begin
        i_start = 1;
        i_periods = 9;
        i_bursts = 9;
      end
      step();
    end
    i_start = 0;
    repeat (4) step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0 leftover", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    step();
    step();
    total++;
    if ({o_osc_phase_rst, o_osc_valid, o_valid, o_busy, o_done} !== 5'b0 || o_data !== '0) begin
      bad++;
      $display("FAIL reset got=%b/%0d want=0", {o_osc_phase_rst, o_osc_valid, o_valid, o_busy, o_done}, o_data);
    end
    rst_n = 1;
    step();
  endtask

  task automatic test_basic();
    int t0;
    nvalid = 0;
    first_valid = -1;
    run_seq(2, 3, 2, -1, t0);
    total++;
    if (nvalid !== 20) begin
      bad++;
      $display("FAIL basic_count got=%0d want=20", nvalid);
    end
    total++;
    if (first_valid !== t0 + 4) begin
      bad++;
      $display("FAIL first_valid got=%0d want=%0d", first_valid, t0 + 4);
    end
  endtask

  task automatic test_zero();
    int t0;
    nvalid = 0;
    run_seq(0, 2, 5, -1, t0);
    total++;
    if (nvalid !== 0) begin
      bad++;
      $display("FAIL zero_count got=%0d want=0", nvalid);
    end
  endtask

  task automatic test_no_gap();
    int t0;
    nvalid = 0;
    run_seq(1, 0, 3, -1, t0);
    total++;
    if (nvalid !== 15) begin
      bad++;
      $display("FAIL nogap_count got=%0d want=15", nvalid);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    nvalid = 0;
    run_seq(2, 1, 2, 5, t0);
    total++;
    if (nvalid !== 20) begin
      bad++;
      $display("FAIL busy_start_count got=%0d want=20", nvalid);
    end
  endtask

  task automatic test_abort();
    int t0;
    nvalid = 0;
    exp_q.push_back(tbl[0]);
    i_start = 1;
    i_periods = 4;
    i_gap_cycles = 0;
    i_bursts = 1;
    step();
    i_start = 0;
    repeat (3) step();
    total++;
    if (o_osc_valid !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre got=%b want=1", o_osc_valid);
    end
    i_abort = 1;
    step();
    i_abort = 0;
    total++;
    if ({o_osc_valid, o_done, o_busy} !== 3'b011) begin
      bad++;
      $display("FAIL abort_done got=%b want=011", {o_osc_valid, o_done, o_busy});
    end
    step();
    total++;
    if ({o_done, o_busy} !== 2'b00) begin
      bad++;
      $display("FAIL abort_idle got=%b want=00", {o_done, o_busy});
    end
    run_seq(1, 0, 1, -1, t0);
    total++;
    if (nvalid !== 6) begin
      bad++;
      $display("FAIL abort_count got=%0d want=6", nvalid);
    end
  endtask

  task automatic test_abort_start_idle();
    i_start = 1;
    i_abort = 1;
    i_periods = 1;
    i_bursts = 1;
    step();
    i_start = 0;
    i_abort = 0;
    total++;
    if ({o_busy, o_osc_phase_rst, o_done} !== 3'b000) begin
      bad++;
      $display("FAIL abort_start got=%b want=000", {o_busy, o_osc_phase_rst, o_done});
    end
    step();
  endtask

  task automatic test_reset_mid_gap();
    push_exp(1, 1);
    i_start = 1;
    i_periods = 1;
    i_gap_cycles = 5;
    i_bursts = 2;
    step();
    i_start = 0;
    repeat (8) step();
    total++;
    if ({o_osc_valid, o_busy} !== 2'b01) begin
      bad++;
      $display("FAIL in_gap got=%b want=01", {o_osc_valid, o_busy});
    end
    #2 rst_n = 0;
    #1;
    total++;
    if ({o_osc_phase_rst, o_osc_valid, o_valid, o_busy, o_done} !== 5'b0 || o_data !== '0) begin
      bad++;
      $display("FAIL async_rst got=%b want=00000", {o_osc_phase_rst, o_osc_valid, o_valid, o_busy, o_done});
    end
    step();
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({o_done, o_busy} !== 2'b00) begin
        bad++;
        $display("FAIL post_rst k=%0d got=%b want=00", k, {o_done, o_busy});
      end
      step();
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rst_drain got=%0d want=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_no_gap();
    test_back_to_back();
    test_abort();
    test_abort_start_idle();
    test_reset_mid_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
